// File: rtl/cve2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cve2_pkg
// Description : Shared types for the CVE2 core slice (writeback stage).
// Revision    : 1.0 - initial release
// ============================================================================
package cve2_pkg;

    // Kind of instruction held in writeback; loads/stores wait on the LSU.
    typedef enum logic [1:0] {
        WB_INSTR_LOAD  = 2'b00,
        WB_INSTR_STORE = 2'b01,
        WB_INSTR_OTHER = 2'b10
    } wb_instr_type_e;

endpackage
`default_nettype wire

// File: rtl/cve2_wb_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : cve2_wb_stage_if
// Description : ID/EX to writeback handover bundle (instruction + ready).
// Revision    : 1.0 - initial release
// ============================================================================
interface cve2_wb_stage_if
    import cve2_pkg::*;
#(
    parameter int ADDR_W = 5
);
    logic                en_wb;
    wb_instr_type_e      instr_type;
    logic [31:0]         pc;
    logic                instr_is_compressed;
    logic                instr_perf_count;
    logic [ADDR_W-1:0]   rf_waddr;
    logic [31:0]         rf_wdata;
    logic                rf_we;
    logic                ready;

    modport master (
        output en_wb, instr_type, pc, instr_is_compressed, instr_perf_count,
               rf_waddr, rf_wdata, rf_we,
        input  ready
    );

    modport slave (
        input  en_wb, instr_type, pc, instr_is_compressed, instr_perf_count,
               rf_waddr, rf_wdata, rf_we,
        output ready
    );
endinterface
`default_nettype wire

// File: rtl/cve2_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : cve2_wb_stage
// Description : Writeback stage; registered one-entry stage or passthrough.
// Revision    : 1.0 - initial release
// ============================================================================
module cve2_wb_stage
    import cve2_pkg::*;
#(
    parameter bit WritebackStage = 1'b1,
    parameter int RegFileAddrW   = 5
) (
    input  wire logic                    clk_i,
    input  wire logic                    rst_i,

    input  wire logic                    en_wb_i,
    input  wb_instr_type_e               instr_type_wb_i,
    input  wire logic [31:0]             pc_id_i,
    input  wire logic                    instr_is_compressed_id_i,
    input  wire logic                    instr_perf_count_id_i,

    input  wire logic [RegFileAddrW-1:0] rf_waddr_id_i,
    input  wire logic [31:0]             rf_wdata_id_i,
    input  wire logic                    rf_we_id_i,

    input  wire logic [31:0]             rf_wdata_lsu_i,
    input  wire logic                    rf_we_lsu_i,
    input  wire logic                    lsu_resp_valid_i,
    input  wire logic                    lsu_resp_err_i,

    output logic                         ready_wb_o,
    output logic                         rf_write_wb_o,
    output logic                         outstanding_load_wb_o,
    output logic                         outstanding_store_wb_o,
    output logic [31:0]                  pc_wb_o,
    output logic [31:0]                  rf_wdata_fwd_wb_o,

    output logic [RegFileAddrW-1:0]      rf_waddr_wb_o,
    output logic [31:0]                  rf_wdata_wb_o,
    output logic                         rf_we_wb_o,

    output logic                         perf_instr_ret_wb_o,
    output logic                         perf_instr_ret_compressed_wb_o,
    output logic                         perf_instr_ret_wb_spec_o,
    output logic                         perf_instr_ret_compressed_wb_spec_o,

    output logic                         instr_done_wb_o
);

    logic        rf_we_id_sel;
    logic [31:0] rf_wdata_id_sel;
    logic        lsu_err_resp;

    assign lsu_err_resp = lsu_resp_valid_i & lsu_resp_err_i;

    generate
        if (WritebackStage) begin : g_writeback_stage
            logic                    wb_valid_q;
            logic                    wb_valid_d;
            logic                    wb_capture;
            logic                    wb_done;
            logic [31:0]             pc_q;
            logic [RegFileAddrW-1:0] waddr_q;
            logic [31:0]             wdata_q;
            logic                    we_q;
            wb_instr_type_e          type_q;
            logic                    compressed_q;
            logic                    perf_count_q;

            always_comb begin
                wb_done    = wb_valid_q & ((type_q == WB_INSTR_OTHER) | lsu_resp_valid_i);
                wb_capture = en_wb_i & (~wb_valid_q | wb_done);
                wb_valid_d = wb_valid_q;
                if (wb_capture) begin
                    wb_valid_d = 1'b1;
                end else if (wb_done) begin
                    wb_valid_d = 1'b0;
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    wb_valid_q   <= 1'b0;
                    pc_q         <= 32'h0;
                    waddr_q      <= '0;
                    wdata_q      <= 32'h0;
                    we_q         <= 1'b0;
                    type_q       <= WB_INSTR_OTHER;
                    compressed_q <= 1'b0;
                    perf_count_q <= 1'b0;
                end else begin
                    wb_valid_q <= wb_valid_d;
                    if (wb_capture) begin
                        pc_q         <= pc_id_i;
                        waddr_q      <= rf_waddr_id_i;
                        wdata_q      <= rf_wdata_id_i;
                        we_q         <= rf_we_id_i;
                        type_q       <= instr_type_wb_i;
                        compressed_q <= instr_is_compressed_id_i;
                        perf_count_q <= instr_perf_count_id_i;
                    end
                end
            end

            // Loads and stores never write ID data; load data comes from the LSU.
            assign rf_we_id_sel    = wb_valid_q & we_q & (type_q == WB_INSTR_OTHER);
            assign rf_wdata_id_sel = wdata_q;
            assign rf_waddr_wb_o   = waddr_q;

            assign instr_done_wb_o        = wb_done;
            assign ready_wb_o             = ~wb_valid_q | wb_done;
            assign rf_write_wb_o          = wb_valid_q & we_q;
            assign rf_wdata_fwd_wb_o      = wdata_q;
            assign outstanding_load_wb_o  = wb_valid_q & (type_q == WB_INSTR_LOAD);
            assign outstanding_store_wb_o = wb_valid_q & (type_q == WB_INSTR_STORE);
            assign pc_wb_o                = pc_q;

            assign perf_instr_ret_wb_o                 = wb_done & perf_count_q & ~lsu_err_resp;
            assign perf_instr_ret_compressed_wb_o      = perf_instr_ret_wb_o & compressed_q;
            assign perf_instr_ret_wb_spec_o            = wb_valid_q & perf_count_q & ~wb_done;
            assign perf_instr_ret_compressed_wb_spec_o = perf_instr_ret_wb_spec_o & compressed_q;
        end else begin : g_passthrough
            logic unused_wb_passthrough;

            assign unused_wb_passthrough = ^{pc_id_i, instr_type_wb_i, clk_i, rst_i};

            assign rf_we_id_sel    = rf_we_id_i;
            assign rf_wdata_id_sel = rf_wdata_id_i;
            assign rf_waddr_wb_o   = rf_waddr_id_i;

            assign instr_done_wb_o        = 1'b0;
            assign ready_wb_o             = 1'b1;
            assign rf_write_wb_o          = 1'b0;
            assign rf_wdata_fwd_wb_o      = 32'h0;
            assign outstanding_load_wb_o  = 1'b0;
            assign outstanding_store_wb_o = 1'b0;
            assign pc_wb_o                = 32'h0;

            assign perf_instr_ret_wb_o                 = instr_perf_count_id_i & en_wb_i & ~lsu_err_resp;
            assign perf_instr_ret_compressed_wb_o      = perf_instr_ret_wb_o & instr_is_compressed_id_i;
            assign perf_instr_ret_wb_spec_o            = 1'b0;
            assign perf_instr_ret_compressed_wb_spec_o = 1'b0;
        end
    endgenerate

    // One-hot AND-OR select between ID result and LSU load data.
    assign rf_we_wb_o    = rf_we_id_sel | rf_we_lsu_i;
    assign rf_wdata_wb_o = ({32{rf_we_id_sel}} & rf_wdata_id_sel) |
                           ({32{rf_we_lsu_i}}  & rf_wdata_lsu_i);

    a_rf_write_onehot : assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0({rf_we_id_sel, rf_we_lsu_i}));

    a_no_handover_when_busy : assert property (@(posedge clk_i) disable iff (rst_i)
        en_wb_i |-> ready_wb_o);

endmodule
`default_nettype wire

// File: tb/tb_cve2_wb_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_cve2_wb_stage
// Description : Directed vector bench for cve2_wb_stage (registered + passthrough).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cve2_wb_stage;
    import cve2_pkg::*;

    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;
    localparam wb_instr_type_e OT = WB_INSTR_OTHER;
    localparam wb_instr_type_e LD = WB_INSTR_LOAD;
    localparam wb_instr_type_e ST = WB_INSTR_STORE;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Registered stage instance
    cve2_wb_stage_if #(.ADDR_W(5)) if1 ();
    logic [31:0] lsu1_wdata;
    logic        lsu1_we, rv1, re1;
    logic        o1_rfw, o1_ol, o1_os, o1_rwe, o1_ret, o1_retc, o1_sp, o1_spc, o1_done;
    logic [31:0] o1_pc, o1_fwd, o1_rd;
    logic [4:0]  o1_ra;

    cve2_wb_stage #(.WritebackStage(1'b1), .RegFileAddrW(5)) dut1 (
        .clk_i                               (clk),
        .rst_i                               (rst),
        .en_wb_i                             (if1.en_wb),
        .instr_type_wb_i                     (if1.instr_type),
        .pc_id_i                             (if1.pc),
        .instr_is_compressed_id_i            (if1.instr_is_compressed),
        .instr_perf_count_id_i               (if1.instr_perf_count),
        .rf_waddr_id_i                       (if1.rf_waddr),
        .rf_wdata_id_i                       (if1.rf_wdata),
        .rf_we_id_i                          (if1.rf_we),
        .rf_wdata_lsu_i                      (lsu1_wdata),
        .rf_we_lsu_i                         (lsu1_we),
        .lsu_resp_valid_i                    (rv1),
        .lsu_resp_err_i                      (re1),
        .ready_wb_o                          (if1.ready),
        .rf_write_wb_o                       (o1_rfw),
        .outstanding_load_wb_o               (o1_ol),
        .outstanding_store_wb_o              (o1_os),
        .pc_wb_o                             (o1_pc),
        .rf_wdata_fwd_wb_o                   (o1_fwd),
        .rf_waddr_wb_o                       (o1_ra),
        .rf_wdata_wb_o                       (o1_rd),
        .rf_we_wb_o                          (o1_rwe),
        .perf_instr_ret_wb_o                 (o1_ret),
        .perf_instr_ret_compressed_wb_o      (o1_retc),
        .perf_instr_ret_wb_spec_o            (o1_sp),
        .perf_instr_ret_compressed_wb_spec_o (o1_spc),
        .instr_done_wb_o                     (o1_done)
    );

    // Passthrough instance
    cve2_wb_stage_if #(.ADDR_W(5)) if0 ();
    logic [31:0] lsu0_wdata;
    logic        lsu0_we, rv0, re0;
    logic        o0_rfw, o0_ol, o0_os, o0_rwe, o0_ret, o0_retc, o0_sp, o0_spc, o0_done;
    logic [31:0] o0_pc, o0_fwd, o0_rd;
    logic [4:0]  o0_ra;

    cve2_wb_stage #(.WritebackStage(1'b0), .RegFileAddrW(5)) dut0 (
        .clk_i                               (clk),
        .rst_i                               (rst),
        .en_wb_i                             (if0.en_wb),
        .instr_type_wb_i                     (if0.instr_type),
        .pc_id_i                             (if0.pc),
        .instr_is_compressed_id_i            (if0.instr_is_compressed),
        .instr_perf_count_id_i               (if0.instr_perf_count),
        .rf_waddr_id_i                       (if0.rf_waddr),
        .rf_wdata_id_i                       (if0.rf_wdata),
        .rf_we_id_i                          (if0.rf_we),
        .rf_wdata_lsu_i                      (lsu0_wdata),
        .rf_we_lsu_i                         (lsu0_we),
        .lsu_resp_valid_i                    (rv0),
        .lsu_resp_err_i                      (re0),
        .ready_wb_o                          (if0.ready),
        .rf_write_wb_o                       (o0_rfw),
        .outstanding_load_wb_o               (o0_ol),
        .outstanding_store_wb_o              (o0_os),
        .pc_wb_o                             (o0_pc),
        .rf_wdata_fwd_wb_o                   (o0_fwd),
        .rf_waddr_wb_o                       (o0_ra),
        .rf_wdata_wb_o                       (o0_rd),
        .rf_we_wb_o                          (o0_rwe),
        .perf_instr_ret_wb_o                 (o0_ret),
        .perf_instr_ret_compressed_wb_o      (o0_retc),
        .perf_instr_ret_wb_spec_o            (o0_sp),
        .perf_instr_ret_compressed_wb_spec_o (o0_spc),
        .instr_done_wb_o                     (o0_done)
    );

    typedef struct {
        logic           en;
        wb_instr_type_e typ;
        logic [31:0]    pc;
        logic           we;
        logic [4:0]     wa;
        logic [31:0]    wd;
        logic           perf;
        logic           comp;
        logic           lwe;
        logic [31:0]    ldata;
        logic           rv;
        logic           re;
        logic           x_rdy;
        logic           x_done;
        logic           x_rwe;
        logic [4:0]     x_ra;
        logic [31:0]    x_rd;
        logic           x_ret;
        logic           x_retc;
        logic           x_sp;
        logic           x_spc;
        logic           x_ol;
        logic           x_os;
        logic [31:0]    x_pc;
        logic           x_rfw;
        logic [31:0]    x_fwd;
    } vec_t;

    vec_t v [14];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic drive1(input vec_t t);
        if1.en_wb               = t.en;
        if1.instr_type          = t.typ;
        if1.pc                  = t.pc;
        if1.rf_we               = t.we;
        if1.rf_waddr            = t.wa;
        if1.rf_wdata            = t.wd;
        if1.instr_perf_count    = t.perf;
        if1.instr_is_compressed = t.comp;
        lsu1_we                 = t.lwe;
        lsu1_wdata              = t.ldata;
        rv1                     = t.rv;
        re1                     = t.re;
    endtask

    task automatic drive0(input logic en, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                          input logic perf, input logic comp, input logic rv, input logic re);
        if0.en_wb               = en;
        if0.instr_type          = OT;
        if0.pc                  = 32'h0000_0040;
        if0.rf_we               = we;
        if0.rf_waddr            = wa;
        if0.rf_wdata            = wd;
        if0.instr_perf_count    = perf;
        if0.instr_is_compressed = comp;
        lsu0_we                 = 1'b0;
        lsu0_wdata              = 32'h0;
        rv0                     = rv;
        re0                     = re;
    endtask

    task automatic check_row(input int i, input vec_t t);
        chk($sformatf("r%0d_ready", i),  {31'h0, if1.ready}, {31'h0, t.x_rdy});
        chk($sformatf("r%0d_done", i),   {31'h0, o1_done},   {31'h0, t.x_done});
        chk($sformatf("r%0d_rf_we", i),  {31'h0, o1_rwe},    {31'h0, t.x_rwe});
        chk($sformatf("r%0d_waddr", i),  {27'h0, o1_ra},     {27'h0, t.x_ra});
        chk($sformatf("r%0d_wdata", i),  o1_rd,              t.x_rd);
        chk($sformatf("r%0d_ret", i),    {31'h0, o1_ret},    {31'h0, t.x_ret});
        chk($sformatf("r%0d_ret_c", i),  {31'h0, o1_retc},   {31'h0, t.x_retc});
        chk($sformatf("r%0d_spec", i),   {31'h0, o1_sp},     {31'h0, t.x_sp});
        chk($sformatf("r%0d_spec_c", i), {31'h0, o1_spc},    {31'h0, t.x_spc});
        chk($sformatf("r%0d_out_ld", i), {31'h0, o1_ol},     {31'h0, t.x_ol});
        chk($sformatf("r%0d_out_st", i), {31'h0, o1_os},     {31'h0, t.x_os});
        chk($sformatf("r%0d_pc_wb", i),  o1_pc,              t.x_pc);
        chk($sformatf("r%0d_rf_wr", i),  {31'h0, o1_rfw},    {31'h0, t.x_rfw});
        chk($sformatf("r%0d_fwd", i),    o1_fwd,             t.x_fwd);
    endtask

    initial begin
        vec_t idle;
        //          en typ pc         we wa    wd         pf cp lwe ldata          rv re | rdy dn rwe ra   rd             ret rc sp sc ol os pc_wb      rfw fwd
        idle  = '{N, OT, 32'h0,    N, 5'd0, 32'h0,    N, N, N, 32'h0,        N, N,  Y, N, N, 5'd0, 32'h0,        N, N, N, N, N, N, 32'h0,    N, 32'h0};
        v[0]  = idle;
        v[1]  = '{Y, OT, 32'h10,   Y, 5'd5, 32'h1234, Y, N, N, 32'h0,        N, N,  Y, N, N, 5'd0, 32'h0,        N, N, N, N, N, N, 32'h0,    N, 32'h0};
        v[2]  = '{N, OT, 32'h0,    N, 5'd0, 32'h0,    N, N, N, 32'h0,        N, N,  Y, Y, Y, 5'd5, 32'h1234,     Y, N, N, N, N, N, 32'h10,   Y, 32'h1234};
        v[3]  = '{Y, LD, 32'h80,   Y, 5'd7, 32'h0,    Y, Y, N, 32'h0,        N, N,  Y, N, N, 5'd5, 32'h0,        N, N, N, N, N, N, 32'h10,   N, 32'h1234};
        v[4]  = '{N, OT, 32'h0,    N, 5'd0, 32'h0,    N, N, N, 32'h0,        N, N,  N, N, N, 5'd7, 32'h0,        N, N, Y, Y, Y, N, 32'h80,   Y, 32'h0};
        v[5]  = v[4];
        v[6]  = '{N, OT, 32'h0,    N, 5'd0, 32'h0,    N, N, Y, 32'hCAFEF00D, Y, N,  Y, Y, Y, 5'd7, 32'hCAFEF00D, Y, Y, N, N, Y, N, 32'h80,   Y, 32'h0};
        v[7]  = '{Y, ST, 32'h84,   N, 5'd0, 32'h0,    Y, N, N, 32'h0,        N, N,  Y, N, N, 5'd7, 32'h0,        N, N, N, N, N, N, 32'h80,   N, 32'h0};
        v[8]  = '{N, OT, 32'h0,    N, 5'd0, 32'h0,    N, N, N, 32'h0,        Y, Y,  Y, Y, N, 5'd0, 32'h0,        N, N, N, N, N, Y, 32'h84,   N, 32'h0};
        v[9]  = '{Y, OT, 32'h100,  Y, 5'd1, 32'h11,   Y, N, N, 32'h0,        N, N,  Y, N, N, 5'd0, 32'h0,        N, N, N, N, N, N, 32'h84,   N, 32'h0};
        v[10] = '{Y, OT, 32'h102,  Y, 5'd2, 32'h22,   Y, Y, N, 32'h0,        N, N,  Y, Y, Y, 5'd1, 32'h11,       Y, N, N, N, N, N, 32'h100,  Y, 32'h11};
        v[11] = '{Y, OT, 32'h104,  Y, 5'd3, 32'h33,   N, N, N, 32'h0,        N, N,  Y, Y, Y, 5'd2, 32'h22,       Y, Y, N, N, N, N, 32'h102,  Y, 32'h22};
        v[12] = '{N, OT, 32'h0,    N, 5'd0, 32'h0,    N, N, N, 32'h0,        N, N,  Y, Y, Y, 5'd3, 32'h33,       N, N, N, N, N, N, 32'h104,  Y, 32'h33};
        v[13] = '{N, OT, 32'h0,    N, 5'd0, 32'h0,    N, N, N, 32'h0,        N, N,  Y, N, N, 5'd3, 32'h0,        N, N, N, N, N, N, 32'h104,  N, 32'h33};

        rst = 1'b1;
        drive1(idle);
        drive0(N, N, 5'd0, 32'h0, N, N, N, N);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Registered stage: sequential vector table, state carries row to row
        for (int i = 0; i < 14; i++) begin
            drive1(v[i]);
            #3;
            check_row(i, v[i]);
            @(posedge clk);
            #1;
        end

        // Reset while a load is outstanding drops it silently
        begin
            vec_t ld;
            ld      = idle;
            ld.en   = Y;
            ld.typ  = LD;
            ld.pc   = 32'h200;
            ld.we   = Y;
            ld.wa   = 5'd9;
            ld.perf = Y;
            drive1(ld);
            @(posedge clk);
            #1;
            drive1(idle);
            #3;
            chk("rst_pre_out_ld", {31'h0, o1_ol},     32'h1);
            chk("rst_pre_ready",  {31'h0, if1.ready}, 32'h0);
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            rv1 = 1'b1;
            #3;
            chk("rst_ready",  {31'h0, if1.ready}, 32'h1);
            chk("rst_out_ld", {31'h0, o1_ol},     32'h0);
            chk("rst_done",   {31'h0, o1_done},   32'h0);
            chk("rst_ret",    {31'h0, o1_ret},    32'h0);
            chk("rst_spec",   {31'h0, o1_sp},     32'h0);
            chk("rst_rf_we",  {31'h0, o1_rwe},    32'h0);
            chk("rst_rf_wr",  {31'h0, o1_rfw},    32'h0);
            chk("rst_pc",     o1_pc,              32'h0);
            chk("rst_waddr",  {27'h0, o1_ra},     32'h0);
            rv1 = 1'b0;
            @(posedge clk);
            #1;
        end

        // Passthrough: same-cycle write, constant ready, no speculative counts
        drive0(Y, Y, 5'd4, 32'h0000_ABCD, Y, Y, N, N);
        #3;
        chk("p0_rf_we",  {31'h0, o0_rwe},    32'h1);
        chk("p0_waddr",  {27'h0, o0_ra},     32'h4);
        chk("p0_wdata",  o0_rd,              32'h0000_ABCD);
        chk("p0_ready",  {31'h0, if0.ready}, 32'h1);
        chk("p0_ret",    {31'h0, o0_ret},    32'h1);
        chk("p0_ret_c",  {31'h0, o0_retc},   32'h1);
        chk("p0_spec",   {31'h0, o0_sp},     32'h0);
        chk("p0_spec_c", {31'h0, o0_spc},    32'h0);
        chk("p0_done",   {31'h0, o0_done},   32'h0);
        chk("p0_pc",     o0_pc,              32'h0);
        chk("p0_rf_wr",  {31'h0, o0_rfw},    32'h0);
        @(posedge clk);
        #1;
        drive0(Y, Y, 5'd6, 32'h0000_5555, Y, N, Y, Y);
        #3;
        chk("p1_ret_err", {31'h0, o0_ret},    32'h0);
        chk("p1_ready",   {31'h0, if0.ready}, 32'h1);
        chk("p1_waddr",   {27'h0, o0_ra},     32'h6);
        @(posedge clk);
        #1;
        drive0(N, N, 5'd0, 32'h0, Y, N, N, N);
        #3;
        chk("p2_rf_we",  {31'h0, o0_rwe},    32'h0);
        chk("p2_ret_en", {31'h0, o0_ret},    32'h0);
        chk("p2_ready",  {31'h0, if0.ready}, 32'h1);
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
